// File: rtl/phase_sequencer.sv
// phase_sequencer
// Steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and
// WRITEBACK. Each stage can hold the sequencer in its own state with its stall
// input. A new instruction may start back-to-back from WRITEBACK while run is
// high.
//
// Build option: define PHASE_SEQUENCER_INSTRET_EN to add the retired-instruction
// counter and its instret output port.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no instruction in flight; waits for run
// FETCH     | fetch stage enabled; held by stall_fetch
// DECODE    | decode stage enabled; held by stall_decode
// EXECUTE   | execute stage enabled; held by stall_execute
// MEMORY    | memory stage enabled; held by stall_memory
// WRITEBACK | writeback stage enabled; retires when stall_writeback is low
module phase_sequencer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 stall_fetch,
  input  logic                 stall_decode,
  input  logic                 stall_execute,
  input  logic                 stall_memory,
  input  logic                 stall_writeback,
  output logic                 phase_fetch,
  output logic                 phase_decode,
  output logic                 phase_execute,
  output logic                 phase_memory,
  output logic                 phase_writeback,
  output logic                 busy,
  output logic                 instr_done
`ifdef PHASE_SEQUENCER_INSTRET_EN
  ,
  output logic [CNT_WIDTH-1:0] instret
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  // A zero-width counter is not meaningful; stop elaboration early.
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("phase_sequencer: CNT_WIDTH must be at least 1");
  end

  // State register; reset drops any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and stage enables decoded from the current state.
  always_comb begin
    state_d         = ST_IDLE;
    phase_fetch     = 1'b0;
    phase_decode    = 1'b0;
    phase_execute   = 1'b0;
    phase_memory    = 1'b0;
    phase_writeback = 1'b0;
    busy            = 1'b1;
    instr_done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy    = 1'b0;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_FETCH: begin
        phase_fetch = 1'b1;
        state_d     = stall_fetch ? ST_FETCH : ST_DECODE;
      end
      ST_DECODE: begin
        phase_decode = 1'b1;
        state_d      = stall_decode ? ST_DECODE : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        phase_execute = 1'b1;
        state_d       = stall_execute ? ST_EXECUTE : ST_MEMORY;
      end
      ST_MEMORY: begin
        phase_memory = 1'b1;
        state_d      = stall_memory ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        phase_writeback = 1'b1;
        if (stall_writeback) begin
          state_d = ST_WRITEBACK;
        end else begin
          // Retirement cycle; run chooses a back-to-back fetch or a return to idle.
          instr_done = 1'b1;
          state_d    = run ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        // Unused encodings fall back to idle on the next edge.
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef PHASE_SEQUENCER_INSTRET_EN
  logic [CNT_WIDTH-1:0] instret_q;

  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (instr_done) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
// Directed per-cycle vectors. Each vector drives the inputs for one cycle and
// pushes the hand-written expected outputs for that cycle into a scoreboard
// queue; a monitor on the falling edge pops and compares.
// Define PHASE_SEQUENCER_INSTRET_EN to also check the retire counter.
module tb_phase_sequencer;

  localparam int CW = 4;

  localparam int PI = 0;
  localparam int PF = 1;
  localparam int PD = 2;
  localparam int PE = 3;
  localparam int PM = 4;
  localparam int PW = 5;

  // stall bit order: {fetch, decode, execute, memory, writeback}
  localparam logic [4:0] S0 = 5'b00000;
  localparam logic [4:0] SF = 5'b10000;
  localparam logic [4:0] SD = 5'b01000;
  localparam logic [4:0] SE = 5'b00100;
  localparam logic [4:0] SM = 5'b00010;
  localparam logic [4:0] SW = 5'b00001;

  logic          clk;
  logic          rst;
  logic          run;
  logic          stall_fetch;
  logic          stall_decode;
  logic          stall_execute;
  logic          stall_memory;
  logic          stall_writeback;
  logic          phase_fetch;
  logic          phase_decode;
  logic          phase_execute;
  logic          phase_memory;
  logic          phase_writeback;
  logic          busy;
  logic          instr_done;
`ifdef PHASE_SEQUENCER_INSTRET_EN
  logic [CW-1:0] instret;
`endif

  typedef struct {
    logic [4:0]    ph;
    logic          done;
    logic [CW-1:0] ir;
    string         tag;
  } exp_t;

  exp_t          sb_q[$];
  logic [CW-1:0] exp_instret;
  int            checks;
  int            errors;

  phase_sequencer #(.CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .stall_fetch     (stall_fetch),
    .stall_decode    (stall_decode),
    .stall_execute   (stall_execute),
    .stall_memory    (stall_memory),
    .stall_writeback (stall_writeback),
    .phase_fetch     (phase_fetch),
    .phase_decode    (phase_decode),
    .phase_execute   (phase_execute),
    .phase_memory    (phase_memory),
    .phase_writeback (phase_writeback),
    .busy            (busy),
    .instr_done      (instr_done)
`ifdef PHASE_SEQUENCER_INSTRET_EN
    ,
    .instret         (instret)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] ph_of(input int code);
    case (code)
      PF:      return 5'b10000;
      PD:      return 5'b01000;
      PE:      return 5'b00100;
      PM:      return 5'b00010;
      PW:      return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, queue what that cycle must show.
  task automatic vec(input string tag, input logic r, input logic [4:0] st,
                     input int code, input logic done);
    exp_t e;
    @(posedge clk);
    #1;
    run = r;
    {stall_fetch, stall_decode, stall_execute, stall_memory, stall_writeback} = st;
    e.ph   = ph_of(code);
    e.done = done;
    e.ir   = exp_instret;
    e.tag  = tag;
    sb_q.push_back(e);
    if (done) exp_instret = exp_instret + CW'(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_phase"}, 32'({phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback}), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(instr_done), 32'd0);
`ifdef PHASE_SEQUENCER_INSTRET_EN
    chk({tag, "_instret"}, 32'(instret), 32'd0);
`endif
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, "_phase"}, 32'({phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback}), 32'(e.ph));
      chk({e.tag, "_busy"}, 32'(busy), 32'(|e.ph));
      chk({e.tag, "_done"}, 32'(instr_done), 32'(e.done));
`ifdef PHASE_SEQUENCER_INSTRET_EN
      chk({e.tag, "_instret"}, 32'(instret), 32'(e.ir));
`endif
    end
  end

  initial begin
    checks          = 0;
    errors          = 0;
    exp_instret     = '0;
    rst             = 1'b1;
    run             = 1'b0;
    stall_fetch     = 1'b0;
    stall_decode    = 1'b0;
    stall_execute   = 1'b0;
    stall_memory    = 1'b0;
    stall_writeback = 1'b0;

    // Reset held across clock edges, then released with run low.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) vec("idle", 1'b0, S0, PI, 1'b0);

    // Three back-to-back instructions, no stalls.
    vec("b2b_start", 1'b1, S0, PI, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vec("b2b_f", 1'b1, S0, PF, 1'b0);
      vec("b2b_d", 1'b1, S0, PD, 1'b0);
      vec("b2b_e", 1'b1, S0, PE, 1'b0);
      vec("b2b_m", 1'b1, S0, PM, 1'b0);
      vec("b2b_w", (k < 2) ? 1'b1 : 1'b0, S0, PW, 1'b1);
    end
    vec("b2b_idle", 1'b0, S0, PI, 1'b0);

    // Execute stalled three cycles, foreign stall_fetch toggling, run dropped.
    vec("stx_start", 1'b1, S0, PI, 1'b0);
    vec("stx_f", 1'b0, S0, PF, 1'b0);
    vec("stx_d", 1'b0, S0, PD, 1'b0);
    vec("stx_e1", 1'b0, SE | SF, PE, 1'b0);
    vec("stx_e2", 1'b0, SE, PE, 1'b0);
    vec("stx_e3", 1'b0, SE | SF, PE, 1'b0);
    vec("stx_e4", 1'b0, SF, PE, 1'b0);
    vec("stx_m", 1'b0, SF, PM, 1'b0);
    vec("stx_w", 1'b0, S0, PW, 1'b1);
    vec("stx_idle", 1'b0, S0, PI, 1'b0);

    // Stalls in fetch, decode, memory and writeback; foreign stalls ignored.
    vec("sto_start", 1'b1, SW | SM, PI, 1'b0);
    vec("sto_f1", 1'b0, SF, PF, 1'b0);
    vec("sto_f2", 1'b0, SD, PF, 1'b0);
    vec("sto_d1", 1'b0, SD | SM, PD, 1'b0);
    vec("sto_d2", 1'b0, SE, PD, 1'b0);
    vec("sto_e", 1'b0, SM | SW, PE, 1'b0);
    vec("sto_m1", 1'b0, SM, PM, 1'b0);
    vec("sto_m2", 1'b0, SW, PM, 1'b0);
    vec("sto_w1", 1'b1, SW, PW, 1'b0);
    vec("sto_w2", 1'b0, SF, PW, 1'b1);
    vec("sto_idle", 1'b0, S0, PI, 1'b0);

    // run high for a single cycle gives exactly one instruction.
    vec("one_start", 1'b1, S0, PI, 1'b0);
    vec("one_f", 1'b0, S0, PF, 1'b0);
    vec("one_d", 1'b0, S0, PD, 1'b0);
    vec("one_e", 1'b0, S0, PE, 1'b0);
    vec("one_m", 1'b0, S0, PM, 1'b0);
    vec("one_w", 1'b0, S0, PW, 1'b1);
    vec("one_idle1", 1'b0, S0, PI, 1'b0);
    vec("one_idle2", 1'b0, S0, PI, 1'b0);

    // Reset asserted mid-cycle while in MEMORY discards the instruction.
    vec("rstm_start", 1'b1, S0, PI, 1'b0);
    vec("rstm_f", 1'b0, S0, PF, 1'b0);
    vec("rstm_d", 1'b0, S0, PD, 1'b0);
    vec("rstm_e", 1'b0, S0, PE, 1'b0);
    vec("rstm_m", 1'b0, S0, PM, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    exp_instret = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) vec("rstm_idle", 1'b0, S0, PI, 1'b0);

    // Seventeen back-to-back instructions; a 4-bit counter wraps to 1.
    vec("wrap_start", 1'b1, S0, PI, 1'b0);
    for (int k = 0; k < 17; k++) begin
      vec("wrap_f", 1'b1, S0, PF, 1'b0);
      vec("wrap_d", 1'b1, S0, PD, 1'b0);
      vec("wrap_e", 1'b1, S0, PE, 1'b0);
      vec("wrap_m", 1'b1, S0, PM, 1'b0);
      vec("wrap_w", (k < 16) ? 1'b1 : 1'b0, S0, PW, 1'b1);
    end
    vec("wrap_idle1", 1'b0, S0, PI, 1'b0);
    vec("wrap_idle2", 1'b0, S0, PI, 1'b0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
